// File: rtl/bridge_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bridge_arbiter_pkg
// Shared definitions for the two-master system-bridge arbiter: FSM state
// encoding, the default lock hold limit and the idle bus value.
// Configuration macro: ARB_ROUND_ROBIN_EN (consumed by the arbiter files).
// -----------------------------------------------------------------------------
package bridge_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_OWN0 = 2'b01;
  localparam logic [1:0] ST_OWN1 = 2'b10;

  localparam int MAX_HOLD_DEFAULT = 8;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byteen;
  } bus_t;

  // All-zero payload: byteen=0 means no write can reach the bridge.
  localparam bus_t BUS_IDLE = '{addr: 32'h0, wdata: 32'h0, byteen: 4'h0};

  function automatic logic [1:0] own_state(input logic owner);
    return owner ? ST_OWN1 : ST_OWN0;
  endfunction

endpackage

// File: rtl/bridge_arbiter_arb_pick.sv
// -----------------------------------------------------------------------------
// bridge_arbiter_arb_pick
// Combinational next-owner selection from the effective requests.
// Configuration macro: ARB_ROUND_ROBIN_EN
//   defined   : contested pick goes to the master that is not last_owner
//   undefined : fixed priority, master 0 wins a contested pick
// Ports:
//   req_i        [1:0] effective requests (bit N = master N)
//   last_owner_i       master that owned the bus most recently (RR only)
//   owner_o            selected master, meaningful when valid_o=1
//   valid_o            at least one effective request present
// -----------------------------------------------------------------------------
module bridge_arbiter_arb_pick (
  input  logic [1:0] req_i,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic       last_owner_i,
`endif
  output logic       owner_o,
  output logic       valid_o
);

  assign valid_o = |req_i;

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    if (req_i == 2'b11) owner_o = ~last_owner_i;
    else                owner_o = req_i[1];
  end
`else
  assign owner_o = ~req_i[0];
`endif

endmodule

// File: rtl/bridge_arbiter.sv
// -----------------------------------------------------------------------------
// bridge_arbiter
// Shares the single system-bridge slave port between master 0 (CPU data port)
// and master 1 (loader/DMA). One transfer completes per granted cycle; lock
// gives bounded back-to-back ownership (MAX_HOLD cycles under contention).
// Configuration macro: ARB_ROUND_ROBIN_EN (round-robin contested pick and
// last_owner tracking; fixed m0 priority when undefined).
// Ports:
//   clk, reset (async, active low)
//   mN_req/mN_lock/mN_addr/mN_wdata/mN_byteen  master N request and payload
//   mN_gnt                                     master N owns the bus this cycle
//   mN_rdata                                   bridge read data (valid on gnt)
//   b_adress/b_Wdata/b_byteen                  muxed payload to the bridge
//   b_Rdata                                    combinational bridge read data
// -----------------------------------------------------------------------------
module bridge_arbiter
  import bridge_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_lock,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_byteen,
  output logic        m0_gnt,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_lock,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_byteen,
  output logic        m1_gnt,
  output logic [31:0] m1_rdata,
  output logic [31:0] b_adress,
  output logic [31:0] b_Wdata,
  output logic [3:0]  b_byteen,
  input  logic [31:0] b_Rdata
);

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

  logic [1:0] state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic [1:0] eff_req;
  logic       pick_owner, pick_valid;
  bus_t       bus;

  // The owner's request was served this cycle unless it asked to keep the bus.
  always_comb begin
    eff_req = {m1_req, m0_req};
    if (state_q == ST_OWN0 && !m0_lock) eff_req[0] = 1'b0;
    if (state_q == ST_OWN1 && !m1_lock) eff_req[1] = 1'b0;
  end

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (state_q == ST_OWN0) last_d = 1'b0;
    if (state_q == ST_OWN1) last_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_q <= 1'b1;
    else        last_q <= last_d;
  end

  bridge_arbiter_arb_pick u_arb_pick (
    .req_i        (eff_req),
    .last_owner_i (last_q),
    .owner_o      (pick_owner),
    .valid_o      (pick_valid)
  );
`else
  bridge_arbiter_arb_pick u_arb_pick (
    .req_i   (eff_req),
    .owner_o (pick_owner),
    .valid_o (pick_valid)
  );
`endif

  // Locked owner keeps the bus until the hold limit is hit while the other
  // master waits; that forced hand-over bypasses the pick policy.
  always_comb begin
    state_d = ST_IDLE;
    if (state_q == ST_OWN0 && m0_lock && m0_req)
      state_d = (hold_q == HOLD_LIMIT && m1_req) ? ST_OWN1 : ST_OWN0;
    else if (state_q == ST_OWN1 && m1_lock && m1_req)
      state_d = (hold_q == HOLD_LIMIT && m0_req) ? ST_OWN0 : ST_OWN1;
    else if (pick_valid)
      state_d = own_state(pick_owner);
  end

  always_comb begin
    hold_d = 8'h00;
    if (state_d == state_q && state_q != ST_IDLE)
      hold_d = (hold_q < HOLD_LIMIT) ? hold_q + 8'h01 : hold_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      hold_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    bus = BUS_IDLE;
    case (state_q)
      ST_OWN0: bus = '{addr: m0_addr, wdata: m0_wdata, byteen: m0_byteen};
      ST_OWN1: bus = '{addr: m1_addr, wdata: m1_wdata, byteen: m1_byteen};
      default: bus = BUS_IDLE;
    endcase
  end

  assign m0_gnt   = (state_q == ST_OWN0);
  assign m1_gnt   = (state_q == ST_OWN1);
  assign b_adress = bus.addr;
  assign b_Wdata  = bus.wdata;
  assign b_byteen = bus.byteen;
  assign m0_rdata = b_Rdata;
  assign m1_rdata = b_Rdata;

endmodule

// File: tb/tb_bridge_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bridge_arbiter
// Self-checking bench for bridge_arbiter with MAX_HOLD=4. Table-driven grant
// sequence, hand-written lock/write/reset sequences and a randomized run
// against an owner-level reference model. Honours ARB_ROUND_ROBIN_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bridge_arbiter;

  localparam int MH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_lock, m1_req, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_byteen, m1_byteen;
  logic        m0_gnt, m1_gnt;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] b_adress, b_Wdata, b_Rdata;
  logic [3:0]  b_byteen;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bridge_arbiter #(.MAX_HOLD(MH)) dut (
    .clk       (clk),
    .reset     (reset),
    .m0_req    (m0_req),
    .m0_lock   (m0_lock),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_byteen (m0_byteen),
    .m0_gnt    (m0_gnt),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_lock   (m1_lock),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_byteen (m1_byteen),
    .m1_gnt    (m1_gnt),
    .m1_rdata  (m1_rdata),
    .b_adress  (b_adress),
    .b_Wdata   (b_Wdata),
    .b_byteen  (b_byteen),
    .b_Rdata   (b_Rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    m0_req = 0; m0_lock = 0; m0_addr = 0; m0_wdata = 0; m0_byteen = 0;
    m1_req = 0; m1_lock = 0; m1_addr = 0; m1_wdata = 0; m1_byteen = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    b_Rdata = 32'h5A5A_0001;
    #2;
    chk("rst_g0", {31'b0, m0_gnt}, 0);
    chk("rst_g1", {31'b0, m1_gnt}, 0);
    chk("rst_addr", b_adress, 0);
    chk("rst_be", {28'b0, b_byteen}, 0);
    chk("rst_rdata", m1_rdata, 32'h5A5A_0001);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- reference model (owner: -1 idle, 0, 1) ----------------
  function automatic int model_next(input int own, input int hold, input int last,
                                    input logic [1:0] rq, input logic [1:0] lk);
    logic [1:0] er;
    if (own >= 0 && lk[own] && rq[own]) begin
      if (hold == MH - 1 && rq[1-own]) return 1 - own;
      return own;
    end
    er = rq;
    if (own >= 0) er[own] = 1'b0;
    if (er == 2'b00) return -1;
    if (er == 2'b11) begin
`ifdef ARB_ROUND_ROBIN_EN
      return 1 - last;
`else
      return (last >= 0) ? 0 : 0;
`endif
    end
    return er[1] ? 1 : 0;
  endfunction

  typedef struct {
    logic r0, l0, r1, l1;
    logic g0, g1;
  } vec_t;

  vec_t vt[12];

  initial begin
    int run, cnt, got1;
    int mown, mhold, mlast, nown, nhold, nlast;
    logic [1:0] rq, lk;
    logic [31:0] exp_addr, exp_wd;
    logic [3:0]  exp_be;

    // ---------------- table-driven grant sequence ----------------
    vt[0]  = '{1,0,0,0, 0,0};
    vt[1]  = '{1,0,0,0, 1,0};
    vt[2]  = '{1,0,0,0, 0,0};
    vt[3]  = '{0,0,1,0, 1,0};
    vt[4]  = '{1,0,0,0, 0,1};
    vt[5]  = '{1,0,1,0, 1,0};
    vt[6]  = '{1,0,1,0, 0,1};
    vt[7]  = '{0,0,0,0, 1,0};
    vt[8]  = '{0,0,0,0, 0,0};
    vt[9]  = '{1,0,1,0, 0,0};
`ifdef ARB_ROUND_ROBIN_EN
    vt[10] = '{0,0,0,0, 0,1};
`else
    vt[10] = '{0,0,0,0, 1,0};
`endif
    vt[11] = '{0,0,0,0, 0,0};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      tick();
      m0_req = vt[i].r0; m0_lock = vt[i].l0; m0_addr = 32'h100;
      m1_req = vt[i].r1; m1_lock = vt[i].l1; m1_addr = 32'h200;
      #1;
      exp_addr = vt[i].g0 ? 32'h100 : (vt[i].g1 ? 32'h200 : 32'h0);
      chk($sformatf("tbl_g0[%0d]", i), {31'b0, m0_gnt}, {31'b0, vt[i].g0});
      chk($sformatf("tbl_g1[%0d]", i), {31'b0, m1_gnt}, {31'b0, vt[i].g1});
      chk($sformatf("tbl_addr[%0d]", i), b_adress, exp_addr);
    end

    // ---------------- m0 read: request cycle 2, grant cycle 3 ----------------
    do_reset();
    tick();
    tick();
    m0_req = 1; m0_addr = 32'h0000_0010; m0_byteen = 4'h0; b_Rdata = 32'hCAFE_0042;
    #1;
    chk("rd_c2_g0", {31'b0, m0_gnt}, 0);
    tick();
    m0_req = 0;
    #1;
    chk("rd_c3_g0", {31'b0, m0_gnt}, 1);
    chk("rd_addr", b_adress, 32'h10);
    chk("rd_be", {28'b0, b_byteen}, 0);
    chk("rd_rdata", m0_rdata, 32'hCAFE_0042);

    // ---------------- both request from IDLE ----------------
    do_reset();
    tick();
    m0_req = 1; m1_req = 1;
    tick();
    chk("both_first_g0", {31'b0, m0_gnt}, 1);
    chk("both_first_g1", {31'b0, m1_gnt}, 0);
    m0_req = 0;
    tick();
    chk("both_second_g1", {31'b0, m1_gnt}, 1);
    m1_req = 0;

    // ---------------- lock under contention: MAX_HOLD grants ----------------
    do_reset();
    tick();
    m0_req = 1; m0_lock = 1; m1_req = 1;
    run = 0; got1 = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (m1_gnt) begin
        got1 = 1;
        break;
      end
      if (m0_gnt) run++;
    end
    chk("lock_run", run, MH);
    chk("lock_release", got1, 1);

    // ---------------- lock, m1 idle: indefinite ownership ----------------
    do_reset();
    tick();
    m0_req = 1; m0_lock = 1;
    tick();
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (m0_gnt) cnt++;
      tick();
    end
    chk("lock_solo_cnt", cnt, 20);
    chk("lock_solo_hold", {24'b0, dut.hold_q}, MH - 1);

    // ---------------- m1 write: byteen only in the grant cycle ----------------
    do_reset();
    tick();
    m1_req = 1; m1_addr = 32'h7f04; m1_wdata = 32'hDEAD_BEEF; m1_byteen = 4'hF;
    #1;
    chk("wr_idle_be", {28'b0, b_byteen}, 0);
    tick();
    m1_req = 0;
    #1;
    chk("wr_g1", {31'b0, m1_gnt}, 1);
    chk("wr_be", {28'b0, b_byteen}, 4'hF);
    chk("wr_addr", b_adress, 32'h7f04);
    chk("wr_wdata", b_Wdata, 32'hDEAD_BEEF);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("wr_after_be[%0d]", k), {28'b0, b_byteen}, 0);
    end

    // ---------------- reset while OWN1 ----------------
    do_reset();
    tick();
    m1_req = 1; m1_lock = 1; m1_byteen = 4'hF;
    tick();
    chk("rst_mid_pre_g1", {31'b0, m1_gnt}, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid_g1", {31'b0, m1_gnt}, 0);
    chk("rst_mid_be", {28'b0, b_byteen}, 0);
    clear_inputs();
    m0_req = 1; m1_req = 1;
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("rst_mid_pick_g0", {31'b0, m0_gnt}, 1);
    chk("rst_mid_pick_g1", {31'b0, m1_gnt}, 0);

    // ---------------- randomized run vs reference model ----------------
    do_reset();
    nown = -1; nhold = 0; nlast = 1;
    for (int i = 0; i < 400; i++) begin
      tick();
      mown = nown; mhold = nhold; mlast = nlast;
      rq[0] = ($urandom_range(0, 9) < 7);
      rq[1] = ($urandom_range(0, 9) < 6);
      lk[0] = ($urandom_range(0, 9) < 5);
      lk[1] = ($urandom_range(0, 9) < 5);
      m0_req = rq[0]; m0_lock = lk[0];
      m1_req = rq[1]; m1_lock = lk[1];
      m0_addr = $urandom; m0_wdata = $urandom; m0_byteen = 4'($urandom_range(0, 15));
      m1_addr = $urandom; m1_wdata = $urandom; m1_byteen = 4'($urandom_range(0, 15));
      b_Rdata = $urandom;
      #1;
      exp_addr = (mown == 0) ? m0_addr   : (mown == 1) ? m1_addr   : 32'h0;
      exp_wd   = (mown == 0) ? m0_wdata  : (mown == 1) ? m1_wdata  : 32'h0;
      exp_be   = (mown == 0) ? m0_byteen : (mown == 1) ? m1_byteen : 4'h0;
      chk("rnd_g0", {31'b0, m0_gnt}, (mown == 0) ? 1 : 0);
      chk("rnd_g1", {31'b0, m1_gnt}, (mown == 1) ? 1 : 0);
      chk("rnd_addr", b_adress, exp_addr);
      chk("rnd_wdata", b_Wdata, exp_wd);
      chk("rnd_be", {28'b0, b_byteen}, {28'b0, exp_be});
      chk("rnd_rdata0", m0_rdata, b_Rdata);
      chk("rnd_rdata1", m1_rdata, b_Rdata);
      chk("rnd_hold", {24'b0, dut.hold_q}, mhold);
      nown  = model_next(mown, mhold, mlast, rq, lk);
      nhold = (nown == mown && mown >= 0) ? ((mhold < MH - 1) ? mhold + 1 : mhold) : 0;
      nlast = (mown >= 0) ? mown : mlast;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bridge_arbiter.md
# bridge_arbiter

Two-master arbiter that shares the single system-bridge slave port between the CPU data port (master 0) and a secondary bus master such as a loader or DMA engine (master 1). It sits between the requesters and the bridge, sequences one transfer per granted cycle, and muxes address, write data and byte enables onto the bridge. It returns the bridge read data to the granted master. Optional lock support gives bounded back-to-back ownership.

## Interface
- MAX_HOLD, 8: maximum consecutive locked cycles one master may own the bus while the other is requesting; legal range 2..255.

- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- m0_req  in  1  master 0 transfer request; held with its payload until granted
- m0_lock  in  1  master 0 asks to keep ownership after the current transfer
- m0_addr  in  32  master 0 byte address
- m0_wdata  in  32  master 0 write data
- m0_byteen  in  4  master 0 byte enables; 0 means read
- m0_gnt  out  1  master 0 owns the bus this cycle; the transfer completes this cycle
- m0_rdata  out  32  read data; valid while m0_gnt=1
- m1_req, m1_lock, m1_addr, m1_wdata, m1_byteen, m1_gnt, m1_rdata: same as master 0, for master 1
- b_adress  out  32  address to the bridge
- b_Wdata  out  32  write data to the bridge
- b_byteen  out  4  byte enables to the bridge
- b_Rdata  in  32  combinational read data from the bridge

## Operation
- FSM states: IDLE, OWN0, OWN1, held in a registered state. mN_gnt = (state==OWNN).
- Bus mux:
  - OWNN drives b_adress, b_Wdata and b_byteen from master N.
  - IDLE drives b_adress=0, b_Wdata=0 and b_byteen=0, so no writes reach the bridge.
  - m0_rdata and m1_rdata both equal b_Rdata. Only the granted master may consume it.
- Next-state evaluation, every cycle:
  - The current owner's req counts as consumed unless its lock=1. A master must drop req, or present a new payload, after its gnt cycle.
  - Owner with lock=1 and req=1 stays owner, unless hold_cnt has reached MAX_HOLD-1 and the other master is requesting. In that case ownership passes to the other master.
  - Otherwise, the next owner is picked from the effective requests. If there are none, the FSM goes to IDLE.
- Pick policy is set by the configuration macro (see Configuration).
- hold_cnt (8 bit):
  - Cleared on any change of owner and in IDLE.
  - Increments each consecutive cycle the same owner is retained and saturates at MAX_HOLD-1.
- last_owner (1 bit): updated to N on every cycle in OWNN.

## Timing
- Reset values, applied asynchronously on reset=0:
  - state=IDLE, hold_cnt=0, last_owner=1.
  - Therefore m0_gnt=0, m1_gnt=0, b_adress=0, b_Wdata=0, b_byteen=0.
  - mN_rdata follows b_Rdata.
- Latency: req first seen high in cycle N (FSM in IDLE) gives gnt in cycle N+1. The transfer completes in cycle N+1.
- Without lock, a lone master gets at most every other cycle (OWN, IDLE, OWN...). Alternating masters get one transfer per cycle.
- With lock held, a single master gets one transfer per cycle indefinitely if the other master is idle. Under contention it gets at most MAX_HOLD consecutive grants.
- Both masters requesting in the same cycle are resolved by the pick policy, never both granted. m0_gnt and m1_gnt are one-hot or zero.
- A req that drops before gnt is a protocol violation. The arbiter still grants on the sampled value, and the granted cycle carries whatever payload is present.
- Reset asserted mid-transfer drops gnt immediately. The bus returns to idle values and the in-flight transfer is discarded.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on a contested pick, grant the master that is not last_owner. m0 wins the first contest after reset.
- Undefined: fixed priority, m0 always wins a contested pick. m1 is still guaranteed service by the MAX_HOLD forced release under lock. last_owner logic is removed.

## Structure
- Shared package holds:
  - the state encoding constants (IDLE=2'b00, OWN0=2'b01, OWN1=2'b10);
  - the default MAX_HOLD;
  - the idle bus constant.
- One sub-module, arb_pick: purely combinational next-owner selection.
  - Inputs: effective requests, last_owner.
  - Output: owner, valid.
  - Both configuration variants live inside arb_pick.

## Test plan
- Reset, then m0 read with addr 0x0000_0010 at cycle 2 → m0_gnt=1 at cycle 3 with b_adress=0x10 and b_byteen=0; m0_rdata equals b_Rdata.
- m0 and m1 both request from IDLE:
  - ARB_ROUND_ROBIN_EN: m0 granted, then m1 on the next cycle.
  - Without it: m0 granted first.
- m0 locked with req held and m1 requesting, MAX_HOLD=4 → exactly 4 consecutive m0_gnt cycles, then m1_gnt=1.
- m0 locked, m1 idle → m0_gnt stays 1 for 20 cycles; hold_cnt saturates at 3.
- m1 write addr 0x7f04, wdata 0xDEAD_BEEF, byteen 4'hF → b_byteen=4'hF only in the m1_gnt cycle; b_byteen=0 in all IDLE cycles.
- reset pulled low while state=OWN1 → m1_gnt and b_byteen are 0 within the same cycle; after release, the first contested pick goes to m0.
